// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4.sv
// 4-bit slice adder: sum = a + b + cin, with the carry out of bit 3.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Plain ripple add of one nibble pair plus incoming carry.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one nibble slice per clock through a single adder4.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high; waiting for an operand pair
// RUN   | one nibble slice added per clock, LSB nibble first
// DONE  | result presented on SUM/Cout with out_valid until out_ready
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] A,
    input  logic [NIBBLE_W*NIBBLES-1:0] B,
    input  logic                        Cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] SUM,
    output logic                        Cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state_r;
    state_t             state_nx;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic [W-1:0]       sum_sh;
    logic               carry_r;
    logic [IDX_W-1:0]   idx;
    logic [NIBBLE_W-1:0] slice_sum;
    logic               slice_cout;

    adder4 u_adder4 (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; in_valid is only looked at in IDLE.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: if (in_valid)         state_nx = RUN;
            RUN:  if (idx == IDX_LAST)  state_nx = DONE;
            DONE: if (out_ready)        state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    // Operand capture and per-slice shifting; sum nibbles enter at the MSB end
    // so that after NIBBLES slices the LSB nibble has reached bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        carry_r <= Cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> NIBBLE_W;
                    b_sh    <= b_sh >> NIBBLE_W;
                    sum_sh  <= (sum_sh >> NIBBLE_W) | (W'(slice_sum) << (W - NIBBLE_W));
                    carry_r <= slice_cout;
                    idx     <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs come straight from registers / state so nothing is combinational from inputs.
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = (state_r == DONE);
        SUM       = sum_sh;
        Cout      = carry_r;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=4.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] SUM;
    logic        Cout;

    int n_checks;
    int n_fail;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .Cout      (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand pair, then wait for out_valid; returns result and latency (-1 on timeout).
    task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output logic [15:0] s, output logic co, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        A        = a;
        B        = b;
        Cin      = c;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
        s  = SUM;
        co = Cout;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (SUM !== 16'h0000 || Cout !== 1'b0) begin
            n_fail++; $display("FAIL reset_sum: got %h/%b want 0000/0", SUM, Cout);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] s; logic co; int lat;
        out_ready = 1'b1;
        do_add(16'h1234, 16'h4321, 1'b0, s, co, lat);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_checks++;
        if (s !== 16'h5555 || co !== 1'b0) begin
            n_fail++; $display("FAIL basic_sum: got %h/%b want 5555/0", s, co);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_drain: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry();
        logic [15:0] s; logic co; int lat;
        out_ready = 1'b1;
        do_add(16'hFFFF, 16'h0001, 1'b0, s, co, lat);
        n_checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            n_fail++; $display("FAIL ripple_sum: got %h/%b want 0000/1", s, co);
        end
        step();
        do_add(16'hFFFF, 16'h0000, 1'b1, s, co, lat);
        n_checks++;
        if (s !== 16'h0000 || co !== 1'b1) begin
            n_fail++; $display("FAIL cin_only_sum: got %h/%b want 0000/1", s, co);
        end
        step();
        do_add(16'h00FF, 16'h0F01, 1'b1, s, co, lat);
        n_checks++;
        if (s !== 16'h1001 || co !== 1'b0) begin
            n_fail++; $display("FAIL cin_mixed_sum: got %h/%b want 1001/0", s, co);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [15:0] s; logic co; int lat;
        out_ready = 1'b0;
        do_add(16'h1111, 16'h2222, 1'b0, s, co, lat);
        n_checks++;
        if (s !== 16'h3333 || co !== 1'b0 || lat !== 4) begin
            n_fail++; $display("FAIL bp_first: got %h/%b lat %0d want 3333/0 lat 4", s, co, lat);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
            step();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || SUM !== 16'h3333 || Cout !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got ov=%b ir=%b %h/%b want ov=1 ir=0 3333/0",
                         i, out_valid, in_ready, SUM, Cout);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_drain: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        A = 16'h0F0F; B = 16'h0101; Cin = 1'b0;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: got ir=%b want 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 20) begin step(); lat++; end
        n_checks++;
        if (lat !== 4 || SUM !== 16'h1010 || Cout !== 1'b0) begin
            n_fail++; $display("FAIL bp_next_sum: got %h/%b lat %0d want 1010/0 lat 4", SUM, Cout, lat);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; logic co; int lat;
        int seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 16'h8000; B = 16'h8000; Cin = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || SUM !== 16'h0000 || Cout !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_abort: got ov=%b ir=%b %h/%b want ov=0 ir=1 0000/0", out_valid, in_ready, SUM, Cout);
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL rst_no_pulse: got %0d out_valid cycles want 0", seen); end
        do_add(16'h0001, 16'h0002, 1'b0, s, co, lat);
        n_checks++;
        if (s !== 16'h0003 || co !== 1'b0 || lat !== 4) begin
            n_fail++; $display("FAIL rst_recover: got %h/%b lat %0d want 0003/0 lat 4", s, co, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int accepts[2];
        logic [15:0] res_s[2];
        logic        res_c[2];
        int n_acc, n_res, cyc;
        logic prev_ready;
        n_acc = 0; n_res = 0; cyc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b0;
        for (int i = 0; i < 30; i++) begin
            prev_ready = in_ready;
            step();
            cyc++;
            if (prev_ready && in_valid && n_acc < 2) begin
                accepts[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    A = 16'h8000; B = 16'h8000;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid && n_res < 2) begin
                res_s[n_res] = SUM;
                res_c[n_res] = Cout;
                n_res++;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc !== 2 || n_res !== 2) begin
            n_fail++; $display("FAIL b2b_count: got acc=%0d res=%0d want 2/2", n_acc, n_res);
        end else begin
            n_checks++;
            if (accepts[1] - accepts[0] !== 6) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d want 6", accepts[1] - accepts[0]);
            end
            n_checks++;
            if (res_s[0] !== 16'hFFFF || res_c[0] !== 1'b0) begin
                n_fail++; $display("FAIL b2b_first: got %h/%b want FFFF/0", res_s[0], res_c[0]);
            end
            n_checks++;
            if (res_s[1] !== 16'h0000 || res_c[1] !== 1'b1) begin
                n_fail++; $display("FAIL b2b_second: got %h/%b want 0000/1", res_s[1], res_c[1]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
